sprite_layer: RTL

Parametrised, pipelined sprite renderer for the VGA display path. For each scan coordinate from the VGA controller, it checks whether the pixel lies inside a WIDTH×HEIGHT sprite placed at (posx, posy) and generates the sprite-ROM address. It returns the 16-bit pixel colour with a transparency key, aligned to a fixed pipeline latency. It adds multi-frame animation, horizontal mirroring and support for synchronous ROMs of configurable latency, so one block serves every animated sprite on screen.

---
 rtl/sprite_layer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sprite_layer.sv
// sprite_layer: pipelined, animated sprite renderer for the VGA display path.
// For every scan coordinate it performs a hit test against a WIDTH x HEIGHT
// sprite placed at (posx, posy), forms the sprite ROM address (with optional
// horizontal mirroring and frame offset) and returns the pixel colour with a
// transparency key, ROM_LAT+2 cycles after the coordinate was presented.
//
// Ports:
//   clk, rst_n        pixel clock, synchronous active-low reset
//   x, y              scan coordinate from the VGA controller
//   posx, posy        sprite top-left corner
//   enable, mirror    sprite visible, horizontal flip
//   anim_en           animation advance enable
//   vsync_tick        one-cycle pulse per video frame
//   rom_addr          registered sprite ROM address
//   rom_data          ROM word, valid ROM_LAT cycles after rom_addr
//   color, is_display output colour and opaque-sprite-pixel flag
//   frame_idx         current animation frame
module sprite_layer #(
  parameter int          WIDTH      = 72,
  parameter int          HEIGHT     = 40,
  parameter int          FRAMES     = 4,
  parameter int          FRAME_HOLD = 8,
  parameter int          ROM_LAT    = 1,
  parameter int          ADDR_W     = 15,
  parameter logic [15:0] KEY_COLOR  = 16'hF81F,
  parameter logic [15:0] BG_COLOR   = 16'hFFFF,
  localparam int         FW         = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic [9:0]        posx,
  input  logic [8:0]        posy,
  input  logic              enable,
  input  logic              mirror,
  input  logic              anim_en,
  input  logic              vsync_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       color,
  output logic              is_display,
  output logic [FW-1:0]     frame_idx
);

  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  // Stage 0: hit test in widened arithmetic so the sprite clips at the
  // screen edge instead of wrapping around.
  logic [10:0] x_w, px_w, px_end, dx, col;
  logic [9:0]  y_w, py_w, py_end, row;
  logic        hit;

  logic [FW-1:0]     frame_q, frame_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]  hit_pipe_q, hit_pipe_d;
  logic [15:0]       color_q, color_d;
  logic              disp_q, disp_d;

  always_comb begin
    x_w    = {1'b0, x};
    px_w   = {1'b0, posx};
    px_end = px_w + 11'(WIDTH);
    y_w    = {1'b0, y};
    py_w   = {1'b0, posy};
    py_end = py_w + 10'(HEIGHT);
    hit    = enable && (x_w >= px_w) && (x_w < px_end) &&
             (y_w >= py_w) && (y_w < py_end);
    dx     = x_w - px_w;
    col    = mirror ? (11'(WIDTH - 1) - dx) : dx;
    row    = y_w - py_w;
  end

  // Address holds on a miss so the ROM sees no needless toggling.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (hit)
      rom_addr_d = ADDR_W'(32'(frame_q) * 32'(WIDTH * HEIGHT) +
                           32'(row) * 32'(WIDTH) + 32'(col));
  end

  // hit_pipe_q[k] is the hit flag of the pixel whose address was issued
  // k cycles ago; bit ROM_LAT lines up with rom_data.
  always_comb begin
    hit_pipe_d    = hit_pipe_q << 1;
    hit_pipe_d[0] = hit;
  end

  always_comb begin
    disp_d  = hit_pipe_q[ROM_LAT] && (rom_data != KEY_COLOR);
    color_d = disp_d ? rom_data : BG_COLOR;
  end

  // Animation: hold counter spans FRAME_HOLD ticks, then frame advances.
  always_comb begin
    hold_d  = hold_q;
    frame_d = frame_q;
    if (vsync_tick && anim_en) begin
      if (hold_q == HW'(FRAME_HOLD - 1)) begin
        hold_d  = '0;
        frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        hold_d  = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      hit_pipe_q <= '0;
      color_q    <= BG_COLOR;
      disp_q     <= 1'b0;
      frame_q    <= '0;
      hold_q     <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit_pipe_q <= hit_pipe_d;
      color_q    <= color_d;
      disp_q     <= disp_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign color      = color_q;
  assign is_display = disp_q;
  assign frame_idx  = frame_q;

endmodule
